// File: rtl/rotate_xform_array_if.sv
// Handshake/data bundle for rotate_xform_array.
// Carries OUT_PAR only when ROTATE_XFORM_PARITY_EN is defined.
interface rotate_xform_array_if #(
  parameter int unsigned WD  = 4,
  parameter int unsigned NCH = 5,
  parameter int unsigned PW  = 3
);
  logic [NCH*WD-1:0] IN;
  logic              IN_VALID;
  logic              IN_READY;
  logic              MODE;
  logic [NCH*WD-1:0] OUT;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [PW-1:0]     PTR;
`ifdef ROTATE_XFORM_PARITY_EN
  logic [NCH-1:0]    OUT_PAR;

  modport master (
    output IN, IN_VALID, MODE, OUT_READY,
    input  IN_READY, OUT, OUT_VALID, PTR, OUT_PAR
  );

  modport slave (
    input  IN, IN_VALID, MODE, OUT_READY,
    output IN_READY, OUT, OUT_VALID, PTR, OUT_PAR
  );
`else
  modport master (
    output IN, IN_VALID, MODE, OUT_READY,
    input  IN_READY, OUT, OUT_VALID, PTR
  );

  modport slave (
    input  IN, IN_VALID, MODE, OUT_READY,
    output IN_READY, OUT, OUT_VALID, PTR
  );
`endif
endinterface

// File: rtl/rotate_xform_array.sv
// Rotating word selector feeding a per-lane bit transform into a one-deep output register.
// Optional per-lane parity output OUT_PAR is enabled by defining ROTATE_XFORM_PARITY_EN.
module rotate_xform_array #(
  parameter int unsigned WD  = 4,
  parameter int unsigned NCH = 5,
  parameter int unsigned PW  = 3
) (
  input  logic                  CLK,
  input  logic                  RST_X,
  rotate_xform_array_if.slave   bus
);

  logic              in_ready_c;
  logic              accept_c;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     ptr_nxt_c;
  logic [WD-1:0]     sel_c;
  logic [NCH*WD-1:0] out_q;
  logic [NCH*WD-1:0] out_nxt_c;
  logic              out_valid_q;

  // bit0 passes through; each higher bit XNORs with its lower neighbour
  function automatic logic [WD-1:0] xform(input logic [WD-1:0] x);
    logic [WD-1:0] y;
    y = '0;
    y[0] = x[0];
    for (int unsigned j = 1; j < WD; j++) y[j] = x[j] ^ ~x[j-1];
    return y;
  endfunction

  assign in_ready_c = !out_valid_q || bus.OUT_READY;
  assign accept_c   = bus.IN_VALID && in_ready_c;
  assign ptr_nxt_c  = (ptr_q == PW'(NCH - 1)) ? '0 : ptr_q + PW'(1);

  always_comb begin
    sel_c = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (ptr_q == PW'(k)) sel_c = bus.IN[k*WD +: WD];
    end
  end

  // odd lanes see the inverted word only in MODE 0
  always_comb begin
    out_nxt_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      out_nxt_c[i*WD +: WD] = xform((!bus.MODE && i[0]) ? ~sel_c : sel_c);
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      ptr_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (accept_c) begin
      ptr_q       <= ptr_nxt_c;
      out_q       <= out_nxt_c;
      out_valid_q <= 1'b1;
    end else if (bus.OUT_READY) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.IN_READY  = in_ready_c;
  assign bus.OUT       = out_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.PTR       = ptr_q;

`ifdef ROTATE_XFORM_PARITY_EN
  logic [NCH-1:0] par_q;
  logic [NCH-1:0] par_nxt_c;

  always_comb begin
    par_nxt_c = '0;
    for (int unsigned i = 0; i < NCH; i++) par_nxt_c[i] = ^out_nxt_c[i*WD +: WD];
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X)        par_q <= '0;
    else if (accept_c) par_q <= par_nxt_c;
  end

  assign bus.OUT_PAR = par_q;
`endif

endmodule

// File: tb/tb_rotate_xform_array.sv
// Scoreboard bench for rotate_xform_array: directed corner cases then randomized traffic.
module tb_rotate_xform_array;
  localparam int unsigned WD  = 4;
  localparam int unsigned NCH = 5;
  localparam int unsigned PW  = 3;
  localparam int unsigned BW  = NCH * WD;

  logic CLK = 1'b0;
  logic RST_X = 1'b0;
  always #5 CLK = ~CLK;

  rotate_xform_array_if #(.WD(WD), .NCH(NCH), .PW(PW)) bus ();

  rotate_xform_array #(.WD(WD), .NCH(NCH), .PW(PW)) dut (
    .CLK   (CLK),
    .RST_X (RST_X),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: pick word PTR, invert for odd lanes in MODE 0, T(x) = x ^ (~(x<<1) with bit0 cleared)
  function automatic logic [BW-1:0] ref_out(input logic [BW-1:0] in_w, input int p, input logic mode);
    int unsigned mask, sel, x, t;
    logic [BW-1:0] r;
    mask = (32'd1 << WD) - 32'd1;
    sel  = 32'(in_w >> (p * WD)) & mask;
    r    = '0;
    for (int i = 0; i < NCH; i++) begin
      x = (mode == 1'b0 && (i % 2) == 1) ? (~sel & mask) : sel;
      t = (x ^ ((~(x << 1)) & ~32'd1)) & mask;
      r = r | (BW'(t) << (i * WD));
    end
    return r;
  endfunction

  function automatic logic [NCH-1:0] ref_par(input logic [BW-1:0] o);
    logic [NCH-1:0] p;
    p = '0;
    for (int i = 0; i < NCH; i++) p[i] = ^(o >> (i * WD) & BW'((1 << WD) - 1));
    return p;
  endfunction

  logic [PW-1:0]  m_ptr;
  logic           m_valid;
  logic [BW-1:0]  sb_q[$];

  // Model: track pointer/valid and push expected result on every accept
  always @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      m_ptr   <= '0;
      m_valid <= 1'b0;
      sb_q.delete();
    end else if (bus.IN_VALID && (!m_valid || bus.OUT_READY)) begin
      sb_q.push_back(ref_out(bus.IN, int'(m_ptr), bus.MODE));
      m_ptr   <= (int'(m_ptr) == NCH - 1) ? '0 : m_ptr + 1'b1;
      m_valid <= 1'b1;
    end else if (bus.OUT_READY) begin
      m_valid <= 1'b0;
    end
  end

  // Monitor: pop and compare whenever the sink consumes a result
  always @(posedge CLK) begin
    logic [BW-1:0] exp_o;
    if (RST_X && bus.OUT_VALID && bus.OUT_READY) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        exp_o = sb_q.pop_front();
        check("sb_out", 64'(bus.OUT), 64'(exp_o));
`ifdef ROTATE_XFORM_PARITY_EN
        check("sb_par", 64'(bus.OUT_PAR), 64'(ref_par(exp_o)));
`endif
      end
    end
  end

  // Per-cycle control-state checks, sampled mid-cycle
  always @(negedge CLK) begin
    if (RST_X) begin
      check("mon_ptr", 64'(bus.PTR), 64'(m_ptr));
      check("mon_valid", 64'(bus.OUT_VALID), 64'(m_valid));
      check("mon_in_ready", 64'(bus.IN_READY), 64'(!m_valid || bus.OUT_READY));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    #1 RST_X = 1'b0;
    #1 RST_X = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out"}, 64'(bus.OUT), 64'd0);
    check({tag, "_valid"}, 64'(bus.OUT_VALID), 64'd0);
    check({tag, "_ptr"}, 64'(bus.PTR), 64'd0);
    check({tag, "_in_ready"}, 64'(bus.IN_READY), 64'd1);
`ifdef ROTATE_XFORM_PARITY_EN
    check({tag, "_par"}, 64'(bus.OUT_PAR), 64'd0);
`endif
  endtask

  initial begin
    bus.IN        = '0;
    bus.IN_VALID  = 1'b0;
    bus.MODE      = 1'b0;
    bus.OUT_READY = 1'b0;
    #1;
    check_reset_state("reset");
    tick();
    RST_X = 1'b1;

    // Single MODE 0 accept of word0 = 0
    bus.IN = '0; bus.MODE = 1'b0; bus.IN_VALID = 1'b1;
    tick();
    bus.IN_VALID = 1'b0;
    check("m0_out", 64'(bus.OUT), 64'h0_EFEFE);
    check("m0_valid", 64'(bus.OUT_VALID), 64'd1);
    check("m0_ptr", 64'(bus.PTR), 64'd1);
`ifdef ROTATE_XFORM_PARITY_EN
    check("m0_par", 64'(bus.OUT_PAR), 64'b10101);
`endif

    // MODE 1, word0 = 5 from a fresh reset
    pulse_reset();
    bus.IN = BW'(20'h00005); bus.MODE = 1'b1; bus.IN_VALID = 1'b1;
    tick();
    check("m1_out", 64'(bus.OUT), 64'h1_1111);
    check("m1_ptr", 64'(bus.PTR), 64'd1);

    // Stall: sink not ready, source keeps offering
    for (int i = 0; i < 3; i++) begin
      bus.IN = BW'($urandom);
      #1;
      check("stall_in_ready", 64'(bus.IN_READY), 64'd0);
      tick();
      check("stall_out", 64'(bus.OUT), 64'h1_1111);
      check("stall_ptr", 64'(bus.PTR), 64'd1);
      check("stall_valid", 64'(bus.OUT_VALID), 64'd1);
    end
    bus.OUT_READY = 1'b1; bus.MODE = 1'b0; bus.IN = BW'($urandom);
    #1;
    check("drain_in_ready", 64'(bus.IN_READY), 64'd1);
    tick();
    check("drain_accept_valid", 64'(bus.OUT_VALID), 64'd1);
    check("drain_accept_ptr", 64'(bus.PTR), 64'd2);
    bus.IN_VALID = 1'b0;
    tick();
    check("drain_only_valid", 64'(bus.OUT_VALID), 64'd0);

    // Back-to-back streaming through the pointer wrap
    pulse_reset();
    bus.OUT_READY = 1'b1; bus.IN_VALID = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      bus.IN = BW'($urandom); bus.MODE = 1'($urandom);
      tick();
      check("stream_ptr", 64'(bus.PTR), 64'(k % NCH));
      check("stream_valid", 64'(bus.OUT_VALID), 64'd1);
    end

    // Asynchronous reset mid-stream at PTR 3
    tick();
    tick();
    check("pre_rst_ptr", 64'(bus.PTR), 64'd3);
    #2 RST_X = 1'b0;
    #1;
    check_reset_state("async_rst");
    tick();
    RST_X = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      bus.IN        = BW'($urandom);
      bus.IN_VALID  = ($urandom % 4) != 0;
      bus.MODE      = 1'($urandom);
      bus.OUT_READY = ($urandom % 3) != 0;
      tick();
    end

    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    tick();
    tick();
    check("sb_drain_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
